// File: rtl/ibex_pkg.sv
// Shared Ibex types for the ALU slice: operator and bit-manipulation level encodings.
package ibex_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    RV32BNone,
    RV32BBalanced,
    RV32BOTEarlGrey,
    RV32BFull
  } rv32b_e;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_XNOR,
    ALU_ORN,
    ALU_ANDN,
    ALU_SRA,
    ALU_SRL,
    ALU_SLL,
    ALU_ROR,
    ALU_LT,
    ALU_LTU,
    ALU_GE,
    ALU_GEU,
    ALU_EQ,
    ALU_NE,
    ALU_SLT,
    ALU_SLTU,
    ALU_MIN,
    ALU_MINU,
    ALU_MAX,
    ALU_MAXU,
    ALU_CLZ
  } alu_op_e;

  // Ops that feed operand B inverted (+1 via the LSB trick) into the adder.
  function automatic logic alu_negate(alu_op_e op);
    case (op)
      ALU_SUB, ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU,
      ALU_SLT, ALU_SLTU, ALU_MIN, ALU_MAX, ALU_MINU, ALU_MAXU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ibex_alu_reg_if.sv
// Operand/result bundle between the execute stage and the registered ALU.
interface ibex_alu_reg_if;
  import ibex_pkg::*;

  alu_op_e                      operator_i;
  logic [XLEN-1:0]              operand_a_i;
  logic [XLEN-1:0]              operand_b_i;
  logic                         instr_first_cycle_i;
  logic [XLEN:0]                multdiv_operand_a_i;
  logic [XLEN:0]                multdiv_operand_b_i;
  logic                         multdiv_sel_i;
  logic [1:0][XLEN-1:0]         imd_val_q_i;
  logic [1:0][XLEN-1:0]         imd_val_d_o;
  logic [1:0]                   imd_val_we_o;
  logic [XLEN-1:0]              adder_result_o;
  logic [XLEN+1:0]              adder_result_ext_o;
  logic [XLEN-1:0]              result_o;
  logic                         comparison_result_o;
  logic                         is_equal_result_o;

  modport master (
    output operator_i, operand_a_i, operand_b_i, instr_first_cycle_i,
           multdiv_operand_a_i, multdiv_operand_b_i, multdiv_sel_i, imd_val_q_i,
    input  imd_val_d_o, imd_val_we_o, adder_result_o, adder_result_ext_o,
           result_o, comparison_result_o, is_equal_result_o
  );

  modport slave (
    input  operator_i, operand_a_i, operand_b_i, instr_first_cycle_i,
           multdiv_operand_a_i, multdiv_operand_b_i, multdiv_sel_i, imd_val_q_i,
    output imd_val_d_o, imd_val_we_o, adder_result_o, adder_result_ext_o,
           result_o, comparison_result_o, is_equal_result_o
  );

endinterface

// File: rtl/ibex_alu_shifter.sv
// 32-bit logarithmic barrel shifter; left shifts reuse the right-shift stages on bit-reversed data.
module ibex_alu_shifter
  import ibex_pkg::*;
(
  input  logic [XLEN-1:0]    operand_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               left_i,
  input  logic               arith_i,
  output logic [XLEN-1:0]    result_o
);

  logic            fill;
  logic [XLEN-1:0] rev_in;
  logic [XLEN-1:0] shifted;

  always_comb begin
    fill = arith_i & ~left_i & operand_i[XLEN-1];
    for (int i = 0; i < XLEN; i++) begin
      rev_in[i] = left_i ? operand_i[XLEN-1-i] : operand_i[i];
    end
    shifted = rev_in;
    for (int s = 0; s < SHAMT_W; s++) begin
      if (shamt_i[s]) begin
        shifted = (shifted >> (1 << s)) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> (1 << s)));
      end
    end
    for (int i = 0; i < XLEN; i++) begin
      result_o[i] = left_i ? shifted[XLEN-1-i] : shifted[i];
    end
  end

endmodule

// File: rtl/ibex_alu_reg.sv
// Ibex execute-stage ALU with all results registered (one cycle latency).
// Zbb min/max/andn/orn/xnor are built only with IBEX_ALU_ZBB_EN defined and RV32B != RV32BNone.
module ibex_alu_reg
  import ibex_pkg::*;
#(
  parameter rv32b_e RV32B = RV32BNone
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ibex_alu_reg_if.slave  alu
);

`ifdef IBEX_ALU_ZBB_EN
  localparam bit ZBB_EN = (RV32B != RV32BNone);
`else
  localparam bit ZBB_EN = 1'b0 && (RV32B != RV32BNone);
`endif

  logic            negate;
  logic [XLEN:0]   adder_in_a;
  logic [XLEN:0]   adder_in_b;
  logic [XLEN+1:0] adder_ext;
  logic [XLEN-1:0] adder_res;
  logic            is_equal;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] shift_res;
  logic            cmp_op;
  logic            cmp_c;
  logic [XLEN-1:0] result_c;
  logic            unused_inputs;

  assign unused_inputs = ^{alu.instr_first_cycle_i, alu.imd_val_q_i};

  assign alu.imd_val_d_o  = '0;
  assign alu.imd_val_we_o = '0;

  // Shared adder; the appended LSB turns inverted B into two's-complement subtraction.
  always_comb begin
    negate = alu_negate(alu.operator_i);
    if (alu.multdiv_sel_i) begin
      adder_in_a = alu.multdiv_operand_a_i;
      adder_in_b = alu.multdiv_operand_b_i;
    end else begin
      adder_in_a = {alu.operand_a_i, 1'b1};
      adder_in_b = {alu.operand_b_i, 1'b0} ^ {(XLEN+1){negate}};
    end
  end

  assign adder_ext = {1'b0, adder_in_a} + {1'b0, adder_in_b};
  assign adder_res = adder_ext[XLEN:1];

  assign is_equal = (alu.operand_a_i == alu.operand_b_i);
  assign lt_s     = ($signed(alu.operand_a_i) < $signed(alu.operand_b_i));
  assign lt_u     = (alu.operand_a_i < alu.operand_b_i);

  ibex_alu_shifter u_shifter (
    .operand_i (alu.operand_a_i),
    .shamt_i   (alu.operand_b_i[SHAMT_W-1:0]),
    .left_i    (alu.operator_i == ALU_SLL),
    .arith_i   (alu.operator_i == ALU_SRA),
    .result_o  (shift_res)
  );

  // Result mux; anything unrecognised or disabled yields zero.
  always_comb begin
    cmp_op   = 1'b0;
    cmp_c    = 1'b0;
    result_c = '0;
    case (alu.operator_i)
      ALU_ADD, ALU_SUB:          result_c = adder_res;
      ALU_XOR:                   result_c = alu.operand_a_i ^ alu.operand_b_i;
      ALU_OR:                    result_c = alu.operand_a_i | alu.operand_b_i;
      ALU_AND:                   result_c = alu.operand_a_i & alu.operand_b_i;
      ALU_SLL, ALU_SRL, ALU_SRA: result_c = shift_res;
      ALU_LT, ALU_SLT:   begin cmp_op = 1'b1; cmp_c = lt_s;      end
      ALU_LTU, ALU_SLTU: begin cmp_op = 1'b1; cmp_c = lt_u;      end
      ALU_GE:            begin cmp_op = 1'b1; cmp_c = ~lt_s;     end
      ALU_GEU:           begin cmp_op = 1'b1; cmp_c = ~lt_u;     end
      ALU_EQ:            begin cmp_op = 1'b1; cmp_c = is_equal;  end
      ALU_NE:            begin cmp_op = 1'b1; cmp_c = ~is_equal; end
      ALU_MIN:  if (ZBB_EN) result_c = lt_s ? alu.operand_a_i : alu.operand_b_i;
      ALU_MAX:  if (ZBB_EN) result_c = lt_s ? alu.operand_b_i : alu.operand_a_i;
      ALU_MINU: if (ZBB_EN) result_c = lt_u ? alu.operand_a_i : alu.operand_b_i;
      ALU_MAXU: if (ZBB_EN) result_c = lt_u ? alu.operand_b_i : alu.operand_a_i;
      ALU_ANDN: if (ZBB_EN) result_c = alu.operand_a_i & ~alu.operand_b_i;
      ALU_ORN:  if (ZBB_EN) result_c = alu.operand_a_i | ~alu.operand_b_i;
      ALU_XNOR: if (ZBB_EN) result_c = ~(alu.operand_a_i ^ alu.operand_b_i);
      default: ;
    endcase
    if (cmp_op) begin
      result_c = XLEN'(cmp_c);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu.adder_result_o      <= '0;
      alu.adder_result_ext_o  <= '0;
      alu.result_o            <= '0;
      alu.comparison_result_o <= 1'b0;
      alu.is_equal_result_o   <= 1'b0;
    end else begin
      alu.adder_result_o      <= adder_res;
      alu.adder_result_ext_o  <= adder_ext;
      alu.result_o            <= result_c;
      alu.comparison_result_o <= cmp_c;
      alu.is_equal_result_o   <= is_equal;
    end
  end

endmodule

// File: tb/tb_ibex_alu_reg.sv
// Bench for ibex_alu_reg: directed boundary steps plus random ops against an arithmetic reference model.
module tb_ibex_alu_reg;
  import ibex_pkg::*;

`ifdef IBEX_ALU_ZBB_EN
  localparam bit ZBB = 1'b1;
`else
  localparam bit ZBB = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        cmp;
    logic        eq;
    logic [31:0] add;
    logic [33:0] ext;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  alu_op_e ops[$];

  ibex_alu_reg_if bus ();

  ibex_alu_reg #(.RV32B(RV32BFull)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .alu   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                 logic sel, logic [32:0] ma, logic [32:0] mb);
    exp_t e;
    logic neg;
    e   = '0;
    neg = op inside {ALU_SUB, ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU,
                     ALU_SLT, ALU_SLTU, ALU_MIN, ALU_MAX, ALU_MINU, ALU_MAXU};
    // ext = 2*(a+b)+1 when adding, 2*(a-b+2^32) when negating
    if (sel)      e.ext = 34'(ma) + 34'(mb);
    else if (neg) e.ext = 34'(2 * (longint'(a) + 64'sh1_0000_0000 - longint'(b)));
    else          e.ext = 34'(2 * (longint'(a) + longint'(b)) + 1);
    e.add = e.ext[32:1];
    e.eq  = (a == b);
    case (op)
      ALU_ADD, ALU_SUB: e.res = e.add;
      ALU_XOR:  e.res = a ^ b;
      ALU_OR:   e.res = a | b;
      ALU_AND:  e.res = a & b;
      ALU_SLL:  e.res = a << b[4:0];
      ALU_SRL:  e.res = a >> b[4:0];
      ALU_SRA:  e.res = 32'($signed(a) >>> b[4:0]);
      ALU_LT, ALU_SLT:   e.cmp = ($signed(a) < $signed(b));
      ALU_LTU, ALU_SLTU: e.cmp = (a < b);
      ALU_GE:   e.cmp = ($signed(a) >= $signed(b));
      ALU_GEU:  e.cmp = (a >= b);
      ALU_EQ:   e.cmp = (a == b);
      ALU_NE:   e.cmp = (a != b);
      ALU_MIN:  if (ZBB) e.res = ($signed(a) < $signed(b)) ? a : b;
      ALU_MAX:  if (ZBB) e.res = ($signed(a) > $signed(b)) ? a : b;
      ALU_MINU: if (ZBB) e.res = (a < b) ? a : b;
      ALU_MAXU: if (ZBB) e.res = (a > b) ? a : b;
      ALU_ANDN: if (ZBB) e.res = a & ~b;
      ALU_ORN:  if (ZBB) e.res = a | ~b;
      ALU_XNOR: if (ZBB) e.res = ~(a ^ b);
      default: ;
    endcase
    if (op inside {ALU_LT, ALU_SLT, ALU_LTU, ALU_SLTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE})
      e.res = {31'b0, e.cmp};
    return e;
  endfunction

  task automatic chk(string tag, logic [33:0] obs, logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_res"}, 34'(bus.result_o), 34'h0);
    chk({tag, "_cmp"}, 34'(bus.comparison_result_o), 34'h0);
    chk({tag, "_eq"},  34'(bus.is_equal_result_o), 34'h0);
    chk({tag, "_add"}, 34'(bus.adder_result_o), 34'h0);
    chk({tag, "_ext"}, bus.adder_result_ext_o, 34'h0);
  endtask

  // Apply one operation, clock it through, compare every output against the model.
  task automatic step(string tag, alu_op_e op, logic [31:0] a, logic [31:0] b,
                      logic sel = 1'b0, logic [32:0] ma = '0, logic [32:0] mb = '0);
    exp_t e;
    e = model(op, a, b, sel, ma, mb);
    bus.operator_i          = op;
    bus.operand_a_i         = a;
    bus.operand_b_i         = b;
    bus.multdiv_sel_i       = sel;
    bus.multdiv_operand_a_i = ma;
    bus.multdiv_operand_b_i = mb;
    bus.instr_first_cycle_i = 1'($urandom);
    bus.imd_val_q_i         = {$urandom, $urandom};
    @(posedge clk);
    #1;
    chk({tag, "_res"}, 34'(bus.result_o), 34'(e.res));
    chk({tag, "_cmp"}, 34'(bus.comparison_result_o), 34'(e.cmp));
    chk({tag, "_eq"},  34'(bus.is_equal_result_o), 34'(e.eq));
    chk({tag, "_add"}, 34'(bus.adder_result_o), 34'(e.add));
    chk({tag, "_ext"}, bus.adder_result_ext_o, e.ext);
  endtask

  initial begin
    alu_op_e o;
    o = o.first();
    for (int i = 0; i < o.num(); i++) begin
      ops.push_back(o);
      o = o.next();
    end

    bus.operator_i          = ALU_ADD;
    bus.operand_a_i         = 32'h1234_5678;
    bus.operand_b_i         = 32'h1111_1111;
    bus.multdiv_sel_i       = 1'b0;
    bus.multdiv_operand_a_i = '0;
    bus.multdiv_operand_b_i = '0;
    bus.instr_first_cycle_i = 1'b0;
    bus.imd_val_q_i         = '0;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("imd_d",  34'(bus.imd_val_d_o[0] | bus.imd_val_d_o[1]), 34'h0);
    chk("imd_we", 34'(bus.imd_val_we_o), 34'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 20; i++) begin
      step("eq_sweep", ALU_EQ, 32'(i), 32'(i));
      chk("eq_sweep_cmp1", 34'(bus.comparison_result_o), 34'h1);
      chk("eq_sweep_add0", 34'(bus.adder_result_o), 34'h0);
    end

    step("ne", ALU_NE, 32'd7, 32'd9);
    chk("ne_cmp", 34'(bus.comparison_result_o), 34'h1);
    chk("ne_eq",  34'(bus.is_equal_result_o), 34'h0);
    step("lt", ALU_LT, 32'hFFFF_FFFF, 32'd1);
    chk("lt_cmp", 34'(bus.comparison_result_o), 34'h1);
    step("ltu", ALU_LTU, 32'hFFFF_FFFF, 32'd1);
    chk("ltu_cmp", 34'(bus.comparison_result_o), 34'h0);
    step("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    chk("add_wrap_res", 34'(bus.result_o), 34'h0);
    chk("add_wrap_c33", 34'(bus.adder_result_ext_o[33]), 34'h1);
    step("sub", ALU_SUB, 32'd5, 32'd7);
    chk("sub_res", 34'(bus.result_o), 34'hFFFF_FFFE);
    step("sub_min", ALU_SUB, 32'h8000_0000, 32'h8000_0000);
    chk("sub_min_res", 34'(bus.result_o), 34'h0);
    chk("sub_min_eq",  34'(bus.is_equal_result_o), 34'h1);
    step("sra31", ALU_SRA, 32'h8000_0000, 32'd31);
    chk("sra31_res", 34'(bus.result_o), 34'hFFFF_FFFF);
    step("srl31", ALU_SRL, 32'h8000_0000, 32'd31);
    chk("srl31_res", 34'(bus.result_o), 34'h1);
    step("sll31", ALU_SLL, 32'd1, 32'd31);
    chk("sll31_res", 34'(bus.result_o), 34'h8000_0000);
    step("sll0", ALU_SLL, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    chk("sll0_res", 34'(bus.result_o), 34'hDEAD_BEEF);
    step("sra0", ALU_SRA, 32'h9ABC_DEF0, 32'd0);
    chk("sra0_res", 34'(bus.result_o), 34'h9ABC_DEF0);
    step("multdiv", ALU_ADD, 32'd100, 32'd200, 1'b1, 33'd3, 33'd5);
    chk("multdiv_ext", bus.adder_result_ext_o, 34'd8);
    step("min", ALU_MIN, 32'hFFFF_FFFD, 32'd2);
    chk("min_res", 34'(bus.result_o), ZBB ? 34'hFFFF_FFFD : 34'h0);
    step("ror_unsup", ALU_ROR, 32'h1234_5678, 32'd4);
    chk("ror_unsup_res", 34'(bus.result_o), 34'h0);

    // Reset dropped in between edges must clear outputs without waiting for a clock.
    step("pre_rst", ALU_ADD, 32'h1234_5678, 32'h0000_0001);
    #2 rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic        sel;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sel = ($urandom_range(0, 7) == 0);
      step("rand", ops[$urandom_range(0, ops.size() - 1)], a, b, sel,
           {1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_alu_reg.md
Name: ibex_alu_reg

Overview:
- 32-bit integer ALU for the Ibex execute stage. Covers add/sub, logic, shifts, signed/unsigned compare and equality, plus an optional Zbb subset.
- Also provides the shared 33-bit adder path to the multiplier/divider.
- Combinational datapath; every output is registered, giving one cycle of latency.

Parameters:
- RV32B, RV32BNone (ibex_pkg::rv32b_e): bit-manipulation level. Any value other than RV32BNone allows the Zbb ops, but only when the macro below is defined.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- operator_i  in  alu_op_e  operation select
- operand_a_i  in  32  operand A
- operand_b_i  in  32  operand B
- instr_first_cycle_i  in  1  first-cycle flag; unused by this block
- multdiv_operand_a_i  in  33  adder A input when multdiv_sel_i=1
- multdiv_operand_b_i  in  33  adder B input when multdiv_sel_i=1
- multdiv_sel_i  in  1  route multdiv operands to the adder
- imd_val_q_i  in  2x32  intermediate values; unused
- imd_val_d_o  out  2x32  intermediate values; constant 0
- imd_val_we_o  out  2  intermediate write enables; constant 0
- adder_result_o  out  32  registered adder result
- adder_result_ext_o  out  34  registered full adder result
- result_o  out  32  registered ALU result
- comparison_result_o  out  1  registered comparison outcome
- is_equal_result_o  out  1  registered (operand_a_i == operand_b_i)

Behaviour:
- Reset: while rst_i=1 (asynchronous assert), all registered outputs are 0. The first update is the first rising edge after deassertion.
- Latency: inputs sampled at rising edge N appear on outputs after edge N.
- Adder, multdiv_sel_i=0:
  - inA = {operand_a_i,1'b1}; inB = {operand_b_i,1'b0} XOR {33{negate}}.
  - negate=1 for SUB, EQ, NE, LT, LTU, GE, GEU, SLT, SLTU, MIN, MAX, MINU, MAXU.
- Adder, multdiv_sel_i=1: inA = multdiv_operand_a_i; inB = multdiv_operand_b_i.
- Adder outputs: ext = zero-extended inA + inB (34 bits); adder_result = ext[32:1]. All 32-bit arithmetic wraps modulo 2^32.
- Logic: XOR, OR, AND give bitwise results.
- Shifts: SLL, SRL, SRA use operand_b_i[4:0]. SRA replicates bit 31.
- Comparison results:
  - LT/SLT: signed a<b. LTU/SLTU: unsigned a<b.
  - GE: signed a>=b. GEU: unsigned a>=b.
  - EQ: a==b. NE: a!=b.
- For those comparison ops: comparison_result_o = the outcome; result_o = {31'b0, outcome}.
- All other ops: comparison_result_o = 0.
- ADD/SUB: result_o = adder_result.
- is_equal_result_o is independent of operator_i.
- Unsupported or disabled operator: result_o = 0, comparison_result_o = 0. Adder outputs still follow the adder inputs.
- Boundaries:
  - a=b=0x80000000, SUB: result 0, is_equal 1.
  - ADD 0xFFFFFFFF+1: result 0, ext[33]=1.
  - Shift by 0: operand A unchanged.
  - SRA by 31 of a negative value: 0xFFFFFFFF.
- Reset asserted mid-stream clears outputs immediately. No state persists across operations.

Optional Feature:
- Macro IBEX_ALU_ZBB_EN.
- Defined (and RV32B != RV32BNone):
  - MIN/MAX signed and MINU/MAXU unsigned select operand A or B via the comparator.
  - ANDN = a & ~b; ORN = a | ~b; XNOR = ~(a ^ b).
- Undefined: these ops are treated as unsupported (result_o 0).

Decomposition:
- Shared package (ibex_pkg): alu_op_e, rv32b_e.
- Natural sub-module: ibex_alu_shifter (32-bit barrel shifter, left/right/arith). Everything else lives in the top.

Test Plan:
- EQ sweep, a=b over 1..20, one pair per cycle -> each cycle after: comparison_result_o=1, is_equal_result_o=1, result_o=1, adder_result_o=0.
- NE with a=7, b=9 -> comparison_result_o=1, is_equal_result_o=0. LT with a=0xFFFFFFFF, b=1 -> 1; LTU with the same operands -> 0.
- ADD 0xFFFFFFFF+1 -> result 0, adder_result_ext_o[33]=1. SUB 5-7 -> 0xFFFFFFFE.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL by 31 -> 1; SLL 1 by 31 -> 0x80000000.
- multdiv_sel_i=1, multdiv A=0x0_0000_0003, multdiv B=0x0_0000_0005 -> adder_result_ext_o=8.
- Assert rst_i mid-stream -> all outputs 0 immediately. With IBEX_ALU_ZBB_EN, MIN -3,2 -> 0xFFFFFFFD; without the macro -> 0.
